// File: rtl/min_serial_pkg.sv
// Shared definitions for the bit-serial minimum/compare unit.
package min_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPARE = 1'b1
    } state_e;

endpackage

// File: rtl/min_serial_if.sv
// Request/result bundle between the datapath and the serial comparator.
interface min_serial_if
    import min_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] min_out;
    logic             a_lt_b;
    logic             eq;

    modport master (
        output start, a, b,
        input  busy, done, min_out, a_lt_b, eq
    );

    modport slave (
        input  start, a, b,
        output busy, done, min_out, a_lt_b, eq
    );

endinterface

// File: rtl/min_serial_bit_cmp_cell.sv
// One MSB-first comparison step: the first differing bit decides, later bits are ignored.
module bit_cmp_cell (
    input  logic ai,
    input  logic bi,
    input  logic decided_in,
    input  logic sel_in,
    output logic decided_out,
    output logic sel_out
);

    logic differ;

    assign differ      = ai ^ bi;
    assign decided_out = decided_in | differ;
    // When b holds the 1 at the first differing bit, a is the smaller operand.
    assign sel_out     = decided_in ? sel_in : (differ & bi);

endmodule

// File: rtl/min_serial.sv
// Bit-serial unsigned comparator: latches operands on start, resolves one bit per clock.
module min_serial
    import min_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    min_serial_if.slave  cmp_if
);

    state_e           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [CW-1:0]    idx_q;
    logic             decided_q;
    logic             sel_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] min_q;
    logic             lt_q;
    logic             eq_q;

    logic             decided_d;
    logic             sel_d;

    bit_cmp_cell u_cell (
        .ai          (ra_q[idx_q]),
        .bi          (rb_q[idx_q]),
        .decided_in  (decided_q),
        .sel_in      (sel_q),
        .decided_out (decided_d),
        .sel_out     (sel_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            min_q     <= '0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (cmp_if.start) begin
                        ra_q      <= cmp_if.a;
                        rb_q      <= cmp_if.b;
                        idx_q     <= CW'(WIDTH - 1);
                        decided_q <= 1'b0;
                        sel_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    decided_q <= decided_d;
                    sel_q     <= sel_d;
                    // Results use this edge's cell output so the LSB still counts.
                    if (idx_q == '0) begin
                        min_q   <= sel_d ? ra_q : rb_q;
                        lt_q    <= sel_d;
                        eq_q    <= ~decided_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmp_if.busy    = busy_q;
    assign cmp_if.done    = done_q;
    assign cmp_if.min_out = min_q;
    assign cmp_if.a_lt_b  = lt_q;
    assign cmp_if.eq      = eq_q;

endmodule

// File: tb/tb_min_serial.sv
// Self-checking bench for min_serial: directed cases plus randomized operations against a behavioural model.
module tb_min_serial;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    min_serial_if #(.WIDTH(WIDTH)) cmp_if ();

    min_serial #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmp_if (cmp_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".busy"}, 32'(cmp_if.busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(cmp_if.done), 32'd0);
        checkOutput({tag, ".min"}, 32'(cmp_if.min_out), 32'd0);
        checkOutput({tag, ".lt"}, 32'(cmp_if.a_lt_b), 32'd0);
        checkOutput({tag, ".eq"}, 32'(cmp_if.eq), 32'd0);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB);
        logic [WIDTH-1:0] expMin;
        expMin = (opA < opB) ? opA : opB;
        checkOutput({tag, ".min"}, 32'(cmp_if.min_out), 32'(expMin));
        checkOutput({tag, ".lt"}, 32'(cmp_if.a_lt_b), 32'(opA < opB));
        checkOutput({tag, ".eq"}, 32'(cmp_if.eq), 32'(opA == opB));
    endtask

    // noise: 0 = quiet while busy, 1 = random start/operands while busy, 2 = start pulse with zeros before E2
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input int noise);
        cmp_if.start = 1'b1;
        cmp_if.a     = opA;
        cmp_if.b     = opB;
        @(posedge clk); #1;
        checkOutput("busyE0", 32'(cmp_if.busy), 32'd1);
        checkOutput("doneE0", 32'(cmp_if.done), 32'd0);
        for (int k = 1; k <= WIDTH; k++) begin
            cmp_if.start = 1'b0;
            if (noise == 1) begin
                cmp_if.start = 1'($urandom_range(0, 1));
                cmp_if.a     = WIDTH'($urandom);
                cmp_if.b     = WIDTH'($urandom);
            end else if (noise == 2 && k == 2) begin
                cmp_if.start = 1'b1;
                cmp_if.a     = '0;
                cmp_if.b     = '0;
            end
            @(posedge clk); #1;
            if (k < WIDTH) begin
                checkOutput("busyMid", 32'(cmp_if.busy), 32'd1);
                checkOutput("doneMid", 32'(cmp_if.done), 32'd0);
            end
        end
        cmp_if.start = 1'b0;
        checkOutput("doneEW", 32'(cmp_if.done), 32'd1);
        checkOutput("busyEW", 32'(cmp_if.busy), 32'd0);
        checkResult("resEW", opA, opB);
        @(posedge clk); #1;
        checkOutput("doneAfter", 32'(cmp_if.done), 32'd0);
        checkOutput("busyAfter", 32'(cmp_if.busy), 32'd0);
        checkResult("held", opA, opB);
    endtask

    // Start held high across two operations: the second is accepted right at the end of the first.
    task automatic backToBack(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                              input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
        cmp_if.start = 1'b1;
        cmp_if.a     = a0;
        cmp_if.b     = b0;
        @(posedge clk); #1;
        cmp_if.a = a1;
        cmp_if.b = b1;
        repeat (WIDTH) @(posedge clk);
        #1;
        checkOutput("b2bDone1", 32'(cmp_if.done), 32'd1);
        checkResult("b2bRes1", a0, b0);
        @(posedge clk); #1;
        cmp_if.start = 1'b0;
        checkOutput("b2bDoneGap", 32'(cmp_if.done), 32'd0);
        checkOutput("b2bBusy2", 32'(cmp_if.busy), 32'd1);
        checkResult("b2bHeld1", a0, b0);
        repeat (WIDTH - 1) @(posedge clk);
        #1;
        checkOutput("b2bNotYet", 32'(cmp_if.done), 32'd0);
        @(posedge clk); #1;
        checkOutput("b2bDone2", 32'(cmp_if.done), 32'd1);
        checkResult("b2bRes2", a1, b1);
        @(posedge clk); #1;
        checkOutput("b2bIdle", 32'(cmp_if.done) | 32'(cmp_if.busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        cmp_if.start = 1'b0;
        cmp_if.a     = '0;
        cmp_if.b     = '0;
        #2 rst = 1'b1;
        #1 checkCleared("resetInit");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed operations");
        applyStimulus(4'b1011, 4'b1010, 0);
        applyStimulus(4'b1001, 4'b0000, 0);
        applyStimulus(4'b0101, 4'b1100, 0);
        applyStimulus(4'b0110, 4'b0110, 0);
        applyStimulus(4'b0000, 4'b0000, 0);
        applyStimulus(4'b0011, 4'b0001, 2);
        backToBack(4'b0011, 4'b0001, 4'b1000, 4'b1001);

        $display("[TB] reset during compare");
        cmp_if.start = 1'b1;
        cmp_if.a     = 4'b1111;
        cmp_if.b     = 4'b0001;
        @(posedge clk); #1;
        cmp_if.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1 checkCleared("resetMid");
        @(posedge clk); #1;
        checkCleared("resetHold");
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(posedge clk); #1;
            checkCleared("afterReset");
        end
        applyStimulus(4'b0010, 4'b0100, 0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            applyStimulus(ra, rb, 1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
